// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO sequencer for MIPS-style mult/div/mthi/mtlo, with the result precomputed at acceptance.
// Optional multiply-accumulate ops (madd/maddu/msub) are enabled by defining MULDIV_MADD_EN.
module muldiv_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] opA,
   input  logic [31:0] opB,
   input  logic        flush,
   input  logic        outSel,
   output logic        busy,
   output logic        done,
   output logic [31:0] readData,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULDIV_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
`endif

   localparam logic [3:0] MUL_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES = 4'd10;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  count, count_nxt;
   logic [63:0] pending, pending_nxt;
   logic [31:0] hi_nxt, lo_nxt;
   logic        done_nxt;
   logic        accept;

   logic [63:0] hilo;
   logic [63:0] prod_s;
   logic [63:0] prod_u;

   logic        div_signed;
   logic        div_zero;
   logic [31:0] dvd_mag, dvs_mag, dvs_safe;
   logic [31:0] quo_mag, rem_mag, quo, rem;
   logic [63:0] div_res;

   assign hilo   = {hi, lo};
   assign prod_s = $signed({{32{opA[31]}}, opA}) * $signed({{32{opB[31]}}, opB});
   assign prod_u = {32'd0, opA} * {32'd0, opB};

   // One unsigned divider serves both div and divu; signed ops divide magnitudes and fix signs after.
   // 0x80000000 / -1 falls out as 0x80000000 rem 0 because its magnitude 2^31 fits unsigned.
   assign div_signed = (op == OP_DIV);
   assign div_zero   = (opB == 32'd0);
   assign dvd_mag    = (div_signed && opA[31]) ? -opA : opA;
   assign dvs_mag    = (div_signed && opB[31]) ? -opB : opB;
   assign dvs_safe   = div_zero ? 32'd1 : dvs_mag;
   assign quo_mag    = dvd_mag / dvs_safe;
   assign rem_mag    = dvd_mag % dvs_safe;
   assign quo        = (div_signed && (opA[31] ^ opB[31])) ? -quo_mag : quo_mag;
   assign rem        = (div_signed && opA[31]) ? -rem_mag : rem_mag;
   assign div_res    = div_zero ? {opA, 32'hFFFF_FFFF} : {rem, quo};

   assign accept = (state == IDLE) && start && !flush;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_nxt   = state;
      count_nxt   = count;
      pending_nxt = pending;
      hi_nxt      = hi;
      lo_nxt      = lo;
      done_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               case (op)
                  OP_MULT: begin
                     pending_nxt = prod_s;
                     state_nxt   = MUL;
                     count_nxt   = MUL_CYCLES;
                  end
                  OP_MULTU: begin
                     pending_nxt = prod_u;
                     state_nxt   = MUL;
                     count_nxt   = MUL_CYCLES;
                  end
`ifdef MULDIV_MADD_EN
                  OP_MADD: begin
                     pending_nxt = hilo + prod_s;
                     state_nxt   = MUL;
                     count_nxt   = MUL_CYCLES;
                  end
                  OP_MADDU: begin
                     pending_nxt = hilo + prod_u;
                     state_nxt   = MUL;
                     count_nxt   = MUL_CYCLES;
                  end
                  OP_MSUB: begin
                     pending_nxt = hilo - prod_s;
                     state_nxt   = MUL;
                     count_nxt   = MUL_CYCLES;
                  end
`endif
                  OP_DIV, OP_DIVU: begin
                     pending_nxt = div_res;
                     state_nxt   = DIV;
                     count_nxt   = DIV_CYCLES;
                  end
                  OP_MTHI: hi_nxt = opA;
                  OP_MTLO: lo_nxt = opA;
                  default: ;
               endcase
            end
         end
         MUL, DIV: begin
            if (flush) begin
               state_nxt = IDLE;
               count_nxt = 4'd0;
            end else if (count == 4'd1) begin
               hi_nxt    = pending[63:32];
               lo_nxt    = pending[31:0];
               done_nxt  = 1'b1;
               state_nxt = IDLE;
               count_nxt = 4'd0;
            end else begin
               count_nxt = count - 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            count_nxt = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (!reset) begin
         state   <= IDLE;
         count   <= 4'd0;
         pending <= 64'd0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         pending <= pending_nxt;
         hi      <= hi_nxt;
         lo      <= lo_nxt;
         done    <= done_nxt;
      end
   end

   assign busy     = (state != IDLE);
   assign readData = outSel ? hi : lo;

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: op request valid this cycle.
REQ-004 SHALL have port op, input, 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, others none.
REQ-005 SHALL have port opA, input, 32: rs operand.
REQ-006 SHALL have port opB, input, 32: rt operand.
REQ-007 SHALL have port flush, input, 1: cancel in-flight op (bubble/exception).
REQ-008 SHALL have port outSel, input, 1: readData source, 1 = HI, 0 = LO.
REQ-009 SHALL have port busy, output, 1: op in flight; the decode stage stalls mfhi/mflo/mul ops while high.
REQ-010 SHALL have port done, output, 1: one-cycle pulse in the cycle after commit.
REQ-011 SHALL have port readData, output, 32: combinational HI or LO per outSel.
REQ-012 SHALL have ports hi and lo, output, 32 each: architectural HI/LO registers.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV.
REQ-014 SHALL accept start only in IDLE with flush low; start in any other condition is ignored with no state change.
REQ-015 SHALL, on accepted op 1,2,7,8,9, latch the pending result and enter MUL with counter=5.
REQ-016 SHALL, on accepted op 3 or 4, latch the pending result and enter DIV with counter=10.
REQ-017 SHALL decrement the counter each cycle in MUL/DIV; at the edge where counter==1, commit pending to HI/LO, return to IDLE, and assert done for the next cycle.
REQ-018 SHALL hold busy high from the cycle after acceptance through the commit cycle inclusive (5 cycles for MUL, 10 for DIV).
REQ-019 SHALL, for op 5/6, write opA to HI/LO at the accepting edge; busy stays low and done stays low.
REQ-020 SHALL compute mult as signed 64-bit and multu as unsigned 64-bit; HI = bits 63:32, LO = bits 31:0.
REQ-021 SHALL compute madd/maddu as {HI,LO} + product (signed/unsigned) and msub as {HI,LO} - signed product, mod 2^64, using HI/LO at acceptance.
REQ-022 SHALL compute div as signed quotient truncated toward zero into LO with remainder taking the dividend's sign into HI; divu SHALL compute unsigned.
REQ-023 SHALL, for divide by zero (opB==0), commit LO=32'hFFFFFFFF and HI=opA.
REQ-024 SHALL, for signed 32'h80000000 / -1, commit LO=32'h80000000 and HI=0.
REQ-025 SHALL, when flush is high in MUL/DIV, abort to IDLE at that edge with no commit and no done pulse; if flush coincides with the commit edge, flush wins.
REQ-026 SHALL present pre-op HI/LO on readData/hi/lo until the commit edge.

Reset
REQ-027 SHALL, while reset is low, force IDLE, counter=0, HI=0, LO=0, pending=0, busy=0, done=0, independent of clk.
REQ-028 SHALL, on reset mid-operation, discard the op with no commit; the first accepting edge SHALL be the first clk edge after reset deasserts.

Configuration
REQ-029 SHALL support macro MULDIV_MADD_EN: when defined, ops 7/8/9 behave per REQ-021.
REQ-030 SHALL, when MULDIV_MADD_EN is undefined, treat ops 7/8/9 as op 0 (no state change, busy low).

Verification
REQ-031 SHALL cover: mult opA=-3, opB=7 -> busy high 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB, done pulse.
REQ-032 SHALL cover: div opA=-7, opB=2 -> busy high 10 cycles, then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; divu opA=7, opB=0 -> LO=32'hFFFFFFFF, HI=7.
REQ-033 SHALL cover: multu 2x3 accepted, second start in cycle 2 -> ignored; flush in cycle 3 -> IDLE, HI/LO unchanged, no done.
REQ-034 SHALL cover: mthi opA=32'h1234 -> HI=32'h1234 next cycle, busy never high; outSel=1 -> readData=32'h1234.
REQ-035 SHALL cover: HI=0, LO=5, madd 2x3 -> LO=11 with macro defined; unchanged with macro undefined.
REQ-036 SHALL cover: reset low in DIV cycle 4 -> busy low and HI=LO=0 immediately, without a clk edge.
